// File: rtl/seg7_pkg.sv
// Shared definitions for the 8-digit 7-segment scan controller.
//   - HEX_SEG_TABLE : nibble -> segments {a,b,c,d,e,f,g}, 1 = lit
//   - SEG_OFF / CSN_OFF : dark segment bus / all digits deselected
//   - scan_state_e : per-slot phase (BLANK anti-ghost gap, then DRIVE)
package seg7_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  localparam logic [7:0] CSN_OFF = 8'hff;
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Index 0 is the first element.
  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011,  // 9
    7'b1110111,  // A
    7'b0011111,  // b
    7'b1001110,  // C
    7'b0111101,  // d
    7'b1001111,  // E
    7'b1000111   // F
  };

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex-to-7-segment decoder.
//   nibble : input  [3:0] hex digit
//   seg    : output [6:0] segments {a,b,c,d,e,f,g}, 1 = lit
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-segment display.
// One digit is refreshed per slot of SCAN_DIV cycles; the first
// BLANK_CYCLES of each slot deselect every digit to avoid ghosting.
// New values arrive through a valid/ready handshake into a pending
// register and are promoted to the active register only at the frame
// boundary, so a frame never mixes old and new digits.
//
// Ports:
//   clk, resetn          : clock, synchronous active-low reset
//   load_valid/ready     : handshake for a new display value
//   load_data [31:0]     : 8 hex nibbles, nibble i -> digit i
//   load_mask [7:0]      : bit i = 1 shows digit i
//   num_csn   [7:0]      : digit selects, active-low
//   num_a_g   [6:0]      : segments {a..g}, 1 = lit
//   frame_done           : one-cycle pulse after digit 7's slot
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 16,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic [7:0]  load_mask,
  output logic [7:0]  num_csn,
  output logic [6:0]  num_a_g,
  output logic        frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] DIG_LAST  = IDX_W'(NUM_DIGITS - 1);
  // The counter resets to slot 0, so the phase resets to whatever slot 0 is.
  localparam scan_state_e RESET_STATE = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;

  // Scan position
  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0] dig_idx_q, dig_idx_d;
  scan_state_e      state_q, state_d;

  // Value registers
  logic [31:0] active_data_q, active_data_d;
  logic [7:0]  active_mask_q, active_mask_d;
  logic [31:0] pend_data_q, pend_data_d;
  logic [7:0]  pend_mask_q, pend_mask_d;
  logic        pending_q, pending_d;

  // Registered outputs
  logic        load_ready_q, load_ready_d;
  logic [7:0]  num_csn_q, num_csn_d;
  logic [6:0]  num_a_g_q, num_a_g_d;
  logic        frame_done_q, frame_done_d;

  logic              frame_end;
  logic              accept;
  logic [NUM_DIGITS-1:0] digit_on;
  logic [3:0]        cur_nibble;
  logic [6:0]        cur_seg;

  // Slot / digit counters and the BLANK/DRIVE phase of the next slot cycle.
  always_comb begin
    slot_cnt_d = slot_cnt_q + 1'b1;
    dig_idx_d  = dig_idx_q;
    frame_end  = (dig_idx_q == DIG_LAST) && (slot_cnt_q == SLOT_LAST);
    if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d = '0;
      dig_idx_d  = dig_idx_q + 1'b1;
    end
    state_d = (slot_cnt_d < BLANK_END) ? ST_BLANK : ST_DRIVE;
  end

  // Handshake and frame-boundary promotion. Acceptance and promotion can
  // never coincide: ready is low exactly while something is pending.
  always_comb begin
    accept        = load_valid && load_ready_q;
    active_data_d = active_data_q;
    active_mask_d = active_mask_q;
    pend_data_d   = pend_data_q;
    pend_mask_d   = pend_mask_q;
    pending_d     = pending_q;
    if (frame_end && pending_q) begin
      active_data_d = pend_data_q;
      active_mask_d = pend_mask_q;
      pending_d     = 1'b0;
    end
    if (accept) begin
      pend_data_d = load_data;
      pend_mask_d = load_mask;
      pending_d   = 1'b1;
    end
    load_ready_d = !pending_d;
  end

  // digit_on is one-hot (or zero), so its inverse is directly the select bus.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_on
    assign digit_on[gi] = (dig_idx_q == IDX_W'(gi)) && active_mask_q[gi];
  end

  assign cur_nibble = active_data_q[{dig_idx_q, 2'b00} +: 4];

  seg7_hex_dec u_hex_dec (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  // Output drive from the current scan position.
  always_comb begin
    num_csn_d    = CSN_OFF;
    num_a_g_d    = SEG_OFF;
    frame_done_d = frame_end;
    if (state_q == ST_DRIVE && (|digit_on)) begin
      num_csn_d = ~digit_on;
      num_a_g_d = cur_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      slot_cnt_q    <= '0;
      dig_idx_q     <= '0;
      state_q       <= RESET_STATE;
      active_data_q <= 32'h0;
      active_mask_q <= 8'h00;
      pend_data_q   <= 32'h0;
      pend_mask_q   <= 8'h00;
      pending_q     <= 1'b0;
      load_ready_q  <= 1'b1;
      num_csn_q     <= CSN_OFF;
      num_a_g_q     <= SEG_OFF;
      frame_done_q  <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      dig_idx_q     <= dig_idx_d;
      state_q       <= state_d;
      active_data_q <= active_data_d;
      active_mask_q <= active_mask_d;
      pend_data_q   <= pend_data_d;
      pend_mask_q   <= pend_mask_d;
      pending_q     <= pending_d;
      load_ready_q  <= load_ready_d;
      num_csn_q     <= num_csn_d;
      num_a_g_q     <= num_a_g_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign load_ready = load_ready_q;
  assign num_csn    = num_csn_q;
  assign num_a_g    = num_a_g_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (SCAN_DIV=4, BLANK_CYCLES=1).
// The stimulus pushes every accepted load onto a queue; the monitor keeps
// a frame-level reference (absolute cycle position + active value) and
// pops a load at the first frame end strictly after its acceptance.
module tb_seg7_scan_ctrl;

  localparam int SD    = 4;
  localparam int BL    = 1;
  localparam int FRAME = 8 * SD;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = 32'h0;
  logic [7:0]  load_mask = 8'h00;
  logic        load_ready;
  logic [7:0]  num_csn;
  logic [6:0]  num_a_g;
  logic        frame_done;

  seg7_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BL)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_mask  (load_mask),
    .num_csn    (num_csn),
    .num_a_g    (num_a_g),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  mask;
    time         t;
  } load_t;

  load_t exp_q[$];
  int checks = 0;
  int errors = 0;

  logic [6:0] seg_ref [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at t=%0t: got %h required %h", name, $time, got, want);
    end
  endtask

  // Monitor: the display presents an output every cycle.
  initial begin : monitor
    int          pos;
    logic [31:0] act_d;
    logic [7:0]  act_m;
    time         edge_t;
    bit          in_rst;
    int          dig;
    int          slot;
    logic [7:0]  e_csn;
    logic [6:0]  e_seg;
    logic        e_fd;
    logic        e_rdy;
    load_t       l;
    pos   = 0;
    act_d = 32'h0;
    act_m = 8'h00;
    forever begin
      @(posedge clk);
      edge_t = $time;
      in_rst = !resetn;
      #1;
      if (in_rst) begin
        e_csn = 8'hff;
        e_seg = 7'h00;
        e_fd  = 1'b0;
        pos   = 0;
        act_d = 32'h0;
        act_m = 8'h00;
        exp_q.delete();
      end else begin
        dig  = (pos / SD) % 8;
        slot = pos % SD;
        if (slot >= BL && act_m[dig]) begin
          e_csn = ~(8'b1 << dig);
          e_seg = seg_ref[act_d[4*dig +: 4]];
        end else begin
          e_csn = 8'hff;
          e_seg = 7'h00;
        end
        e_fd = ((pos % FRAME) == FRAME - 1);
        if (e_fd && exp_q.size() > 0 && exp_q[0].t < edge_t) begin
          l     = exp_q.pop_front();
          act_d = l.data;
          act_m = l.mask;
        end
        pos++;
      end
      e_rdy = (exp_q.size() == 0);
      chk("num_csn", 32'(num_csn), 32'(e_csn));
      chk("num_a_g", 32'(num_a_g), 32'(e_seg));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
      chk("load_ready", 32'(load_ready), 32'(e_rdy));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      load_valid = 1'b0;
    end
  endtask

  // Holds load_valid until the transfer happens (valid stays high on return).
  task automatic send(input logic [31:0] d, input logic [7:0] m);
    int n;
    bit rdy;
    n = 0;
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = d;
    load_mask  = m;
    forever begin
      rdy = load_ready;
      @(posedge clk);
      if (rdy) begin
        exp_q.push_back('{d, m, $time});
        $display("LOAD data=%h mask=%h t=%0t", d, m, $time);
        return;
      end
      n++;
      if (n > 4 * FRAME) begin
        checks++;
        errors++;
        $display("FAIL load_timeout: load_ready low for %0d cycles, required 1 within %0d", n, 4 * FRAME);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      load_valid = 1'b0;
      n++;
    end while (!frame_done && n < 2 * FRAME);
    if (!frame_done) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: frame_done 0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      load_valid = 1'b0;
      n++;
    end while (!load_ready && n < 4 * FRAME);
    if (!load_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: load_ready 0 after %0d cycles, required 1", n);
    end
  endtask

  initial begin : stim
    repeat (5) @(negedge clk);
    resetn = 1'b1;
    idle(FRAME + 4);

    // Full-mask value, then a half mask.
    send(32'h7654_321F, 8'hff);
    idle(2 * FRAME);
    send($urandom, 8'h0f);
    idle(2 * FRAME);

    // Three back-to-back values held mid-frame.
    wait_frame();
    idle(9);
    send($urandom, 8'hff);
    send($urandom, 8'hff);
    send($urandom, $urandom);
    idle(2 * FRAME);

    // Offer exactly on the boundary cycle with nothing pending.
    wait_ready();
    wait_frame();
    repeat (FRAME - 2) @(negedge clk);
    send(32'hA5C3_E10B, 8'hff);
    idle(3 * FRAME);

    // Randomized traffic.
    for (int i = 0; i < 12; i++) begin
      send($urandom, 8'($urandom));
      idle($urandom_range(0, 40));
    end
    idle(2 * FRAME);

    // Reset during digit 3's drive phase with a value pending.
    wait_ready();
    wait_frame();
    send(32'hDEAD_BEEF, 8'hff);
    idle(13);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    idle(2 * FRAME);
    send(32'h0123_4567, 8'hf5);
    idle(3 * FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
